// File: rtl/vga_sync.sv
// VGA timing generator: pixel-rate divider, h/v scan counters, registered scan
// position and strobes (stage 1), and sync outputs delayed one further clk (stage 2).
module vga_sync #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       o_pix_valid,
    output logic [9:0] o_col,
    output logic [9:0] o_row,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_frame_start,
    output logic       o_line_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    generate
        if (CLK_DIV < 1 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_cfg_err
            $error("vga_sync: CLK_DIV must be >=1 and H/V totals must be <=1024");
        end
    endgenerate

    // Compare in 11 bits so a total or active width of exactly 1024 stays representable.
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       hcnt;
    logic [9:0]       vcnt;
    logic [10:0]      hcnt_x;
    logic [10:0]      vcnt_x;
    logic             tick;
    logic             active;
    logic             hs_hit;
    logic             vs_hit;
    logic             hs_pre;
    logic             vs_pre;

    always_comb begin
        hcnt_x = {1'b0, hcnt};
        vcnt_x = {1'b0, vcnt};
        tick   = (div_cnt == DIV_LAST);
        active = (hcnt_x < H_ACT) && (vcnt_x < V_ACT);
        hs_hit = (hcnt_x >= HS_FIRST) && (hcnt_x <= HS_LAST);
        vs_hit = (vcnt_x >= VS_FIRST) && (vcnt_x <= VS_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            hcnt    <= '0;
            vcnt    <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                if (hcnt_x == H_LAST) begin
                    hcnt <= '0;
                    vcnt <= (vcnt_x == V_LAST) ? '0 : vcnt + 10'd1;
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

    // Stage 1: position and strobes; sync levels are captured here too so that
    // stage 2 reflects the same counter value the renderer saw one clk earlier.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_pix_valid   <= 1'b0;
            o_col         <= '0;
            o_row         <= '0;
            o_frame_start <= 1'b0;
            o_line_start  <= 1'b0;
            hs_pre        <= ~SYNC_POL;
            vs_pre        <= ~SYNC_POL;
        end else begin
            o_pix_valid   <= active;
            o_col         <= active ? hcnt : '0;
            o_row         <= active ? vcnt : '0;
            o_frame_start <= (hcnt == '0) && (vcnt == '0) && (div_cnt == '0);
            o_line_start  <= (hcnt == '0) && (div_cnt == '0);
            hs_pre        <= hs_hit ? SYNC_POL : ~SYNC_POL;
            vs_pre        <= vs_hit ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_hsync <= ~SYNC_POL;
            o_vsync <= ~SYNC_POL;
        end else begin
            o_hsync <= hs_pre;
            o_vsync <= vs_pre;
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboard bench for vga_sync: default 640x480 instance plus a tiny-timing instance
// (CLK_DIV=1, H 8/2/2/2, V 4/1/1/1) exercising wrap, frame timing and mid-frame reset.
module tb_vga_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_d, rst_s;
    logic       d_pv, d_hs, d_vs, d_fs, d_ls;
    logic [9:0] d_col, d_row;
    logic       s_pv, s_hs, s_vs, s_fs, s_ls;
    logic [9:0] s_col, s_row;

    vga_sync u_def (
        .clk(clk), .rst(rst_d), .o_pix_valid(d_pv), .o_col(d_col), .o_row(d_row),
        .o_hsync(d_hs), .o_vsync(d_vs), .o_frame_start(d_fs), .o_line_start(d_ls)
    );

    vga_sync #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small (
        .clk(clk), .rst(rst_s), .o_pix_valid(s_pv), .o_col(s_col), .o_row(s_row),
        .o_hsync(s_hs), .o_vsync(s_vs), .o_frame_start(s_fs), .o_line_start(s_ls)
    );

    typedef struct {
        int         dut;
        int         k;
        logic       pv;
        logic [9:0] col;
        logic [9:0] row;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       ls;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Expected outputs after the k-th clk since reset released (k<0: a reset clk).
    // Stage-1 values show scan position k/d; sync outputs show position (k-1)/d.
    function automatic exp_t model(input int dut, input int k, input int d,
                                   input int ha, input int hfp, input int hsw, input int hbp,
                                   input int va, input int vfp, input int vsw, input int vbp);
        exp_t e;
        int ht, vt, p, h, v, p2, h2, v2;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        e.dut = dut; e.k = k;
        e.pv = 1'b0; e.col = '0; e.row = '0; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0; e.ls = 1'b0;
        if (k >= 0) begin
            p = k / d; h = p % ht; v = (p / ht) % vt;
            e.pv  = (h < ha) && (v < va);
            e.col = e.pv ? 10'(h) : 10'd0;
            e.row = e.pv ? 10'(v) : 10'd0;
            e.fs  = (h == 0) && (v == 0) && (k % d == 0);
            e.ls  = (h == 0) && (k % d == 0);
            if (k > 0) begin
                p2 = (k - 1) / d; h2 = p2 % ht; v2 = (p2 / ht) % vt;
                e.hs = !((h2 >= ha + hfp) && (h2 < ha + hfp + hsw));
                e.vs = !((v2 >= va + vfp) && (v2 < va + vfp + vsw));
            end
        end
        return e;
    endfunction

    int kd = -1;
    int ks = -1;

    task automatic step(input logic rd, input logic rs);
        rst_d = rd;
        rst_s = rs;
        @(posedge clk);
        #1;
        kd = rd ? -1 : kd + 1;
        ks = rs ? -1 : ks + 1;
        q.push_back(model(0, kd, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        q.push_back(model(1, ks, 1, 8, 2, 2, 2, 4, 1, 1, 1));
    endtask

    // Event measurements over the first line (default) / first frame (small).
    int   pv_cnt_d = 0, hs_low_d = 0, hs_fall_d = -1, ls2_d = -1;
    logic prev_hs_d = 1'b1;
    int   hs_low_s = 0, hs_fall_s = -1, vs_low_s = 0, vs_fall_s = -1;
    int   ls_cnt_s = 0, ls_pv_s = 0, ls2_s = -1, fs2_s = -1;
    logic prev_hs_s = 1'b1, prev_vs_s = 1'b1;
    logic seen_reset_s = 1'b0;

    always @(negedge clk) begin
        exp_t e, a;
        while (q.size() > 0) begin
            e = q.pop_front();
            a = e;
            if (e.dut == 0) begin
                a.pv = d_pv; a.col = d_col; a.row = d_row; a.hs = d_hs; a.vs = d_vs; a.fs = d_fs; a.ls = d_ls;
            end else begin
                a.pv = s_pv; a.col = s_col; a.row = s_row; a.hs = s_hs; a.vs = s_vs; a.fs = s_fs; a.ls = s_ls;
            end
            checks++;
            if ({a.pv, a.col, a.row, a.hs, a.vs, a.fs, a.ls} !== {e.pv, e.col, e.row, e.hs, e.vs, e.fs, e.ls}) begin
                errors++;
                $display("FAIL %s k=%0d actual pv=%b col=%0d row=%0d hs=%b vs=%b fs=%b ls=%b required pv=%b col=%0d row=%0d hs=%b vs=%b fs=%b ls=%b",
                         (e.dut == 0) ? "scan_default" : "scan_small", e.k,
                         a.pv, a.col, a.row, a.hs, a.vs, a.fs, a.ls,
                         e.pv, e.col, e.row, e.hs, e.vs, e.fs, e.ls);
            end
            if (e.dut == 0 && e.k >= 0 && e.k < 3200) begin
                if (a.pv === 1'b1) pv_cnt_d++;
                if (a.hs === 1'b0) hs_low_d++;
                if (prev_hs_d === 1'b1 && a.hs === 1'b0 && hs_fall_d < 0) hs_fall_d = e.k;
                prev_hs_d = a.hs;
            end
            if (e.dut == 0 && e.k > 0 && a.ls === 1'b1 && ls2_d < 0) ls2_d = e.k;
            if (e.dut == 1 && e.k < 0 && e.k != -1) seen_reset_s = 1'b1;
            if (e.dut == 1 && e.k >= 0 && e.k < 98 && fs2_s < 0) begin
                if (a.hs === 1'b0) hs_low_s++;
                if (a.vs === 1'b0) vs_low_s++;
                if (prev_hs_s === 1'b1 && a.hs === 1'b0 && hs_fall_s < 0) hs_fall_s = e.k;
                if (prev_vs_s === 1'b1 && a.vs === 1'b0 && vs_fall_s < 0) vs_fall_s = e.k;
                if (a.ls === 1'b1) ls_cnt_s++;
                if (a.ls === 1'b1 && a.pv === 1'b1) ls_pv_s++;
                if (a.ls === 1'b1 && e.k > 0 && ls2_s < 0) ls2_s = e.k;
                prev_hs_s = a.hs;
                prev_vs_s = a.vs;
            end
            if (e.dut == 1 && e.k > 0 && a.fs === 1'b1 && fs2_s < 0) fs2_s = e.k;
        end
    end

    task automatic check_eq(input string nm, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, actual, required);
        end
    endtask

    initial begin
        rst_d = 1'b1;
        rst_s = 1'b1;
        // Small instance: two full frames, then a 1-clk reset at row 2 col 5.
        for (int i = 0; i < 9800; i++) begin
            step(i < 5, (i < 5) || (i == 5 + 196 + 33));
        end
        @(negedge clk);
        #1;
        check_eq("pv_high_line0",     pv_cnt_d,  2560);
        check_eq("hs_low_line0",      hs_low_d,  384);
        check_eq("hs_fall_after_ls",  hs_fall_d, 2625);
        check_eq("line_period_def",   ls2_d,     3200);
        check_eq("line_period_small", ls2_s,     14);
        check_eq("frame_period_small", fs2_s,    98);
        check_eq("hs_low_frame_small", hs_low_s, 14);
        check_eq("hs_fall_small",     hs_fall_s, 11);
        check_eq("vs_low_small",      vs_low_s,  14);
        check_eq("vs_fall_small",     vs_fall_s, 71);
        check_eq("ls_per_frame_small", ls_cnt_s, 7);
        check_eq("ls_valid_small",    ls_pv_s,   4);
        check_eq("queue_drained",     q.size(),  0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
